imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the RISC-V core's decode stage. It extracts and sign- or zero-extends the immediate for every base-ISA format, including CSR zimm, and also reports the immediate format and an illegal-opcode flag. Results pass through STAGES register stages under a valid/ready handshake with flush. It feeds the execute-stage operand mux and branch/jump target adders.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; sets the sign-extension width of imm.
STAGES, 1, number of output register stages; legal values 1..3; sets the latency.
SHAMT_ZEXT, 0, when 1, I-type shifts (funct3 001/101) produce a zero-extended shamt instead of the full sign-extended immediate.

Ports:
clk  input  1  core clock, rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  drops all in-flight entries
in_valid  input  1  inst is valid
in_ready  output  1  block can accept inst this cycle
inst  input  32  instruction word
out_valid  output  1  imm/imm_type/illegal are valid
out_ready  input  1  consumer accepts the output this cycle
imm  output  XLEN  extended immediate
imm_type  output  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z
illegal  output  1  opcode not recognised

Behaviour:
- Decode is purely combinational on inst (opcode inst[6:0], funct3 inst[14:12]), using the opcode.vh macros. The result is captured into stage 0.
- I format (ARI_ITYPE, LOAD, JALR): imm = sext(inst[31:20]).
  - If SHAMT_ZEXT=1 and the opcode is ARI_ITYPE with funct3 001/101: imm = zext(inst[24:20]) when XLEN=32, zext(inst[25:20]) when XLEN=64.
- S format (STORE): sext({inst[31:25], inst[11:7]}).
- B format (BRANCH): sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
- U format (LUI, AUIPC): {inst[31:12], 12'b0}; for XLEN=64, bits 63:32 are sign-extended from inst[31].
- J format (JAL): sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
- Z format (CSR): zext(inst[19:15]).
- R-type (ARI_RTYPE): imm 0, imm_type NONE, illegal 0.
- Any other opcode: imm 0, imm_type NONE, illegal 1. The entry still flows through the pipeline normally.
- Pipeline handshake:
  - Each stage k holds a valid bit plus a payload.
  - Stage k loads when its valid bit is 0 or it advances. The last stage advances when out_ready=1; inner stages advance when the next stage loads.
  - in_ready = stage-0 load condition. This is combinational and depends on out_ready through the chain; no bubble is needed for full throughput.
  - An input is accepted when in_valid && in_ready.
  - The payload must be held stable while out_valid && !out_ready.
- Latency: an input accepted at cycle t appears at out_valid in cycle t+STAGES, provided there is no backpressure. Sustained throughput is 1 per cycle.
- Ordering is strictly FIFO; the pipeline holds at most STAGES entries.
- flush:
  - All valid bits clear on the next edge.
  - The input presented in the flush cycle is dropped, even if in_ready=1.
  - out_valid reads 0 in the cycle after flush.
- flush and out_ready together: any output handshaken in that cycle counts as consumed. Everything else is discarded.
- Reset: all valid bits, imm, imm_type and illegal go to 0 on the edge where rst=1. Reset mid-operation discards everything. in_ready is 1 in the first cycle after reset.
- Payload registers load only when their stage loads. A bubble (valid=0) may carry stale data; the consumer must qualify with out_valid.

Decomposition:
- Shared header imm_types.vh: IMM_NONE..IMM_Z codes and the width constant IMM_TYPE_W=3. Opcodes come from the existing opcode.vh.
- Sub-module imm_decode: combinational, parameterised by XLEN and SHAMT_ZEXT; outputs imm, imm_type, illegal.
- imm_gen_pipe instantiates imm_decode and a generate loop of STAGES register stages.

Test Plan:
1. Default parameters, out_ready=1; inst 0xFFF00093 (addi x1,x0,-1) -> one cycle later out_valid=1, imm=0xFFFFFFFF, imm_type=1, illegal=0.
2. Back-to-back 0xFE000EE3 (beq -4), 0xFF9FF06F (jal -8), 0x123450B7 (lui) -> consecutive outputs:
   - 0xFFFFFFFC type 3
   - 0xFFFFFFF8 type 5
   - 0x12345000 type 4
3. XLEN=64, SHAMT_ZEXT=1; inputs 0x800000B7 and 0x43F0D093 (srai x1,x1,63):
   - 0x800000B7 -> imm 0xFFFFFFFF80000000
   - 0x43F0D093 -> imm 0x000000000000003F type 1
4. STAGES=2, out_ready=0; offer 3 instructions -> in_ready drops after 2 acceptances. Raise out_ready -> outputs emerge in input order, one per cycle, payload stable while stalled.
5. STAGES=3, pipeline full; assert flush and in_valid in the same cycle -> next cycle out_valid=0 and the flushed input never appears. Opcode 0x7F in the following input -> illegal=1, imm=0.
6. Assert rst with 2 entries in flight -> all outputs 0 and out_valid=0 next cycle; in_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for the pipelined immediate generator.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
// Contents: immediate format codes, base-ISA opcodes, shift funct3 values,
// and a helper that spots immediate-form shifts.
package imm_gen_pipe_pkg;

  localparam int IMM_TYPE_W = 3;

  typedef enum logic [IMM_TYPE_W-1:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6
  } imm_type_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  // True for slli / srli / srai, whose immediate field carries a shamt.
  function automatic logic is_shift_imm(input logic [6:0] opc, input logic [2:0] f3);
    return (opc == OPC_ARI_ITYPE) && ((f3 == F3_SLL) || (f3 == F3_SRX));
  endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational immediate extraction for every base-ISA format plus CSR zimm.
// Latency: 0 cycles (pure combinational on inst).
// Backpressure: none; the enclosing pipeline decides when the result is captured.
// Ports: inst (32-bit instruction) in; imm (XLEN), imm_type (format code),
// illegal (opcode not recognised) out.
module imm_gen_pipe_decode
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHAMT_ZEXT = 0
) (
  input  logic [31:0]           inst,
  output logic [XLEN-1:0]       imm,
  output logic [IMM_TYPE_W-1:0] imm_type,
  output logic                  illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  // Sign extension relies on size-casting a $signed operand to XLEN.
  always_comb begin
    imm      = '0;
    imm_type = IMM_NONE;
    illegal  = 1'b0;
    case (opcode)
      OPC_ARI_ITYPE, OPC_LOAD, OPC_JALR: begin
        imm_type = IMM_I;
        if ((SHAMT_ZEXT != 0) && is_shift_imm(opcode, funct3))
          // RV64 shifts use a 6-bit shamt, RV32 a 5-bit one.
          imm = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
        else
          imm = XLEN'($signed(inst[31:20]));
      end
      OPC_STORE: begin
        imm_type = IMM_S;
        imm      = XLEN'($signed({inst[31:25], inst[11:7]}));
      end
      OPC_BRANCH: begin
        imm_type = IMM_B;
        imm      = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_type = IMM_U;
        // On RV64 the upper word follows inst[31].
        imm      = XLEN'($signed({inst[31:12], 12'b0}));
      end
      OPC_JAL: begin
        imm_type = IMM_J;
        imm      = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      end
      OPC_SYSTEM: begin
        imm_type = IMM_Z;
        imm      = XLEN'(inst[19:15]);
      end
      OPC_ARI_RTYPE: begin
        imm_type = IMM_NONE;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator feeding the execute operand mux and target adders.
// Latency: STAGES cycles from acceptance to out_valid; 1 result per cycle sustained.
// Backpressure: valid/ready; stalled stages hold payload, in_ready drops only when every stage is full and out_ready=0.
// Ports: clk, rst (sync, active-high), flush; in_valid/in_ready/inst in;
// out_valid/out_ready, imm, imm_type, illegal out.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int STAGES     = 1,
  parameter int SHAMT_ZEXT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           inst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       imm,
  output logic [IMM_TYPE_W-1:0] imm_type,
  output logic                  illegal
);

  typedef struct packed {
    logic [XLEN-1:0]       imm;
    logic [IMM_TYPE_W-1:0] imm_type;
    logic                  illegal;
  } payload_t;

  payload_t          dec_pay;
  payload_t          stage_pay [STAGES];
  logic              stage_vld [STAGES];
  payload_t          up_pay    [STAGES];
  logic              up_vld    [STAGES];
  // stage_load[STAGES] stands for the consumer, so the last stage needs no special case.
  logic [STAGES:0]   stage_load;

  imm_gen_pipe_decode #(
    .XLEN       (XLEN),
    .SHAMT_ZEXT (SHAMT_ZEXT)
  ) u_decode (
    .inst     (inst),
    .imm      (dec_pay.imm),
    .imm_type (dec_pay.imm_type),
    .illegal  (dec_pay.illegal)
  );

  // A stage loads when it is empty or its occupant moves on; this ripples
  // back from out_ready so a full pipeline still streams without bubbles.
  always_comb begin
    stage_load = '0;
    stage_load[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      stage_load[k] = !stage_vld[k] || stage_load[k+1];
    end
  end

  // Upstream view of each stage; the flush-cycle input never enters.
  always_comb begin
    up_vld[0] = in_valid && !flush;
    up_pay[0] = dec_pay;
    for (int k = 1; k < STAGES; k++) begin
      up_vld[k] = stage_vld[k-1];
      up_pay[k] = stage_pay[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    always_ff @(posedge clk) begin
      if (rst) begin
        stage_vld[k] <= 1'b0;
        stage_pay[k] <= '0;
      end else begin
        if (stage_load[k]) begin
          stage_vld[k] <= up_vld[k];
          stage_pay[k] <= up_pay[k];
        end
        // Flush wins over any load; the payload may go stale, valid gates it.
        if (flush) stage_vld[k] <= 1'b0;
      end
    end
  end

  assign in_ready  = stage_load[0];
  assign out_valid = stage_vld[STAGES-1];
  assign imm       = stage_pay[STAGES-1].imm;
  assign imm_type  = stage_pay[STAGES-1].imm_type;
  assign illegal   = stage_pay[STAGES-1].illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: three configurations of imm_gen_pipe driven by the same
// inputs, each compared against a FIFO-level reference model plus directed vectors.
module tb_imm_gen_pipe;

  localparam int STG [3] = '{1, 3, 2};
  localparam int XL  [3] = '{32, 64, 64};
  localparam int SZ  [3] = '{0, 1, 0};
  localparam logic [6:0] OPS [12] = '{7'h03, 7'h23, 7'h63, 7'h67, 7'h6f, 7'h13,
                                      7'h33, 7'h37, 7'h17, 7'h73, 7'h7f, 7'h0f};

  logic        clk;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] inst;
  logic [2:0]  irdy, ovld, oill;
  logic [2:0]  typ0, typ1, typ2;
  logic [31:0] imm0;
  logic [63:0] imm1, imm2;

  imm_gen_pipe #(.XLEN(32), .STAGES(1), .SHAMT_ZEXT(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(irdy[0]),
    .inst(inst), .out_valid(ovld[0]), .out_ready(out_ready), .imm(imm0),
    .imm_type(typ0), .illegal(oill[0]));
  imm_gen_pipe #(.XLEN(64), .STAGES(3), .SHAMT_ZEXT(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(irdy[1]),
    .inst(inst), .out_valid(ovld[1]), .out_ready(out_ready), .imm(imm1),
    .imm_type(typ1), .illegal(oill[1]));
  imm_gen_pipe #(.XLEN(64), .STAGES(2), .SHAMT_ZEXT(0)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(irdy[2]),
    .inst(inst), .out_valid(ovld[2]), .out_ready(out_ready), .imm(imm2),
    .imm_type(typ2), .illegal(oill[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, passed = 0, fails = 0;

  // Reference model: per configuration, a FIFO of expected results.
  logic [63:0] q_imm [3][8];
  logic [2:0]  q_typ [3][8];
  logic        q_ill [3][8];
  int          q_hd [3], q_tl [3];
  bit   [3:0]  acc_h [3];
  bit   [3:0]  ok_h;
  bit          m_ird [3];
  bit          prev_stall [3];
  bit          prev_rst;
  bit          inited;

  task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s dut%0d: observed %h expected %h", tag, d, obs, exp);
    end
  endtask

  function automatic logic [63:0] o_imm(input int d);
    case (d)
      0:       return {32'b0, imm0};
      1:       return imm1;
      default: return imm2;
    endcase
  endfunction

  function automatic logic [2:0] o_typ(input int d);
    case (d)
      0:       return typ0;
      1:       return typ1;
      default: return typ2;
    endcase
  endfunction

  // Immediate value from the ISA encoding rules, computed as a 64-bit signed number.
  task automatic ref_dec(input logic [31:0] i, input int xl, input int sz,
                         output logic [63:0] im, output logic [2:0] ty, output logic il);
    logic signed [63:0] v;
    v = 0; ty = 3'd0; il = 1'b0;
    case (i[6:0])
      7'h13, 7'h03, 7'h67: begin
        ty = 3'd1;
        if (i[6:0] == 7'h13 && sz == 1 && i[13:12] == 2'b01)
          v = (xl == 64) ? 64'(i[25:20]) : 64'(i[24:20]);
        else
          v = $signed(i[31:20]);
      end
      7'h23: begin ty = 3'd2; v = $signed({i[31:25], i[11:7]}); end
      7'h63: begin ty = 3'd3; v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0}); end
      7'h37, 7'h17: begin ty = 3'd4; v = $signed({i[31:12], 12'h000}); end
      7'h6f: begin ty = 3'd5; v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0}); end
      7'h73: begin ty = 3'd6; v = 64'(i[19:15]); end
      7'h33: ty = 3'd0;
      default: il = 1'b1;
    endcase
    im = (xl == 32) ? {32'b0, v[31:0]} : v;
  endtask

  // Apply inputs, then check everything the model can predict for this cycle.
  task automatic drive(input logic r, input logic f, input logic v, input logic [31:0] ins, input logic o);
    int cnt;
    int hd;
    bit [3:0] msk;
    rst = r; flush = f; in_valid = v; inst = ins; out_ready = o;
    #1;
    for (int d = 0; d < 3; d++) begin
      cnt = q_tl[d] - q_hd[d];
      hd = q_hd[d] & 7;
      m_ird[d] = (cnt < STG[d]) || o;
      if (inited) begin
        chk("in_ready", d, 64'(irdy[d]), 64'(m_ird[d]));
        if (cnt == 0) chk("empty_out_valid", d, 64'(ovld[d]), 64'd0);
        msk = 4'((1 << STG[d]) - 1);
        if ((ok_h & msk) == msk)
          chk("latency_out_valid", d, 64'(ovld[d]), 64'(acc_h[d][STG[d]-1]));
        if (prev_stall[d]) chk("stall_hold_valid", d, 64'(ovld[d]), 64'd1);
        if (prev_rst) begin
          chk("rst_out_valid", d, 64'(ovld[d]), 64'd0);
          chk("rst_imm", d, o_imm(d), 64'd0);
          chk("rst_type", d, 64'(o_typ(d)), 64'd0);
          chk("rst_illegal", d, 64'(oill[d]), 64'd0);
        end
        if (ovld[d] && cnt > 0) begin
          chk("imm", d, o_imm(d), q_imm[d][hd]);
          chk("imm_type", d, 64'(o_typ(d)), 64'(q_typ[d][hd]));
          chk("illegal", d, 64'(oill[d]), 64'(q_ill[d][hd]));
        end
      end
    end
  endtask

  // Advance the model across the coming clock edge, then wait for the next negedge.
  task automatic tick();
    bit acc, pop;
    logic [63:0] e_imm;
    logic [2:0]  e_typ;
    logic        e_ill;
    for (int d = 0; d < 3; d++) begin
      acc = in_valid && m_ird[d] && !flush && !rst;
      pop = inited && ovld[d] && out_ready && (q_tl[d] > q_hd[d]);
      if (pop) q_hd[d]++;
      if (rst || flush) begin
        q_hd[d] = q_tl[d];
      end else if (acc) begin
        ref_dec(inst, XL[d], SZ[d], e_imm, e_typ, e_ill);
        q_imm[d][q_tl[d] & 7] = e_imm;
        q_typ[d][q_tl[d] & 7] = e_typ;
        q_ill[d][q_tl[d] & 7] = e_ill;
        q_tl[d]++;
      end
      acc_h[d] = {acc_h[d][2:0], acc};
      prev_stall[d] = inited && (ovld[d] === 1'b1) && !out_ready && !flush && !rst;
    end
    ok_h = {ok_h[2:0], out_ready && !flush && !rst};
    prev_rst = rst;
    if (rst) inited = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rv;
    for (int d = 0; d < 3; d++) begin
      q_hd[d] = 0; q_tl[d] = 0; acc_h[d] = '0; m_ird[d] = 1'b0; prev_stall[d] = 1'b0;
    end
    ok_h = '0; prev_rst = 1'b0; inited = 1'b0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; inst = '0; out_ready = 1'b0;
    @(negedge clk);

    // Reset; second reset cycle checks the cleared outputs.
    drive(1, 0, 0, 32'h0, 0); tick();
    drive(1, 0, 0, 32'h0, 0); tick();

    // Single addi, then beq / jal / lui back to back on the 1-stage config.
    drive(0, 0, 1, 32'hFFF00093, 1); tick();
    drive(0, 0, 1, 32'hFE000EE3, 1);
    chk("t1_valid", 0, 64'(ovld[0]), 64'd1);
    chk("t1_imm", 0, o_imm(0), 64'h0000_0000_FFFF_FFFF);
    chk("t1_type", 0, 64'(typ0), 64'd1);
    chk("t1_illegal", 0, 64'(oill[0]), 64'd0);
    tick();
    drive(0, 0, 1, 32'hFF9FF06F, 1);
    chk("t2_beq_imm", 0, o_imm(0), 64'h0000_0000_FFFF_FFFC);
    chk("t2_beq_type", 0, 64'(typ0), 64'd3);
    tick();
    drive(0, 0, 1, 32'h123450B7, 1);
    chk("t2_jal_imm", 0, o_imm(0), 64'h0000_0000_FFFF_FFF8);
    chk("t2_jal_type", 0, 64'(typ0), 64'd5);
    tick();
    drive(0, 0, 0, 32'h0, 1);
    chk("t2_lui_imm", 0, o_imm(0), 64'h0000_0000_1234_5000);
    chk("t2_lui_type", 0, 64'(typ0), 64'd4);
    tick();
    for (int n = 0; n < 3; n++) begin drive(0, 0, 0, 32'h0, 1); tick(); end

    // RV64 lui sign extension and zero-extended shamt on the 3-stage config.
    drive(0, 0, 1, 32'h800000B7, 1); tick();
    drive(0, 0, 1, 32'h43F0D093, 1);
    chk("t3_lui32_imm", 0, o_imm(0), 64'h0000_0000_8000_0000);
    tick();
    drive(0, 0, 0, 32'h0, 1);
    chk("t3_srai_sext_imm", 0, o_imm(0), 64'h0000_0000_0000_043F);
    tick();
    drive(0, 0, 0, 32'h0, 1);
    chk("t3_lui64_valid", 1, 64'(ovld[1]), 64'd1);
    chk("t3_lui64_imm", 1, o_imm(1), 64'hFFFF_FFFF_8000_0000);
    tick();
    drive(0, 0, 0, 32'h0, 1);
    chk("t3_shamt_imm", 1, o_imm(1), 64'h0000_0000_0000_003F);
    chk("t3_shamt_type", 1, 64'(typ1), 64'd1);
    tick();
    for (int n = 0; n < 3; n++) begin drive(0, 0, 0, 32'h0, 1); tick(); end

    // Backpressure on the 2-stage config: third offer is refused until out_ready.
    drive(0, 0, 1, 32'hFFF00093, 0); tick();
    drive(0, 0, 1, 32'hFE112E23, 0); tick();
    drive(0, 0, 1, 32'h300FD0F3, 0);
    chk("t4_full_in_ready", 2, 64'(irdy[2]), 64'd0);
    tick();
    drive(0, 0, 1, 32'h300FD0F3, 0);
    chk("t4_stall_valid", 2, 64'(ovld[2]), 64'd1);
    chk("t4_stall_imm", 2, o_imm(2), 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    drive(0, 0, 1, 32'h300FD0F3, 1);
    chk("t4_first_imm", 2, o_imm(2), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t4_resume_in_ready", 2, 64'(irdy[2]), 64'd1);
    tick();
    drive(0, 0, 0, 32'h0, 1);
    chk("t4_second_imm", 2, o_imm(2), 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t4_second_type", 2, 64'(typ2), 64'd2);
    tick();
    drive(0, 0, 0, 32'h0, 1);
    chk("t4_third_imm", 2, o_imm(2), 64'h0000_0000_0000_001F);
    chk("t4_third_type", 2, 64'(typ2), 64'd6);
    tick();
    for (int n = 0; n < 4; n++) begin drive(0, 0, 0, 32'h0, 1); tick(); end

    // Fill the 3-stage config, flush with a live input, then an illegal opcode.
    drive(0, 0, 1, 32'h00100093, 0); tick();
    drive(0, 0, 1, 32'h00200093, 0); tick();
    drive(0, 0, 1, 32'h00300093, 0); tick();
    drive(0, 1, 1, 32'h7FF00093, 0);
    chk("t5_full_in_ready", 1, 64'(irdy[1]), 64'd0);
    chk("t5_full_valid", 1, 64'(ovld[1]), 64'd1);
    tick();
    drive(0, 0, 1, 32'h0000007F, 1);
    chk("t5_flushed_valid", 1, 64'(ovld[1]), 64'd0);
    tick();
    drive(0, 0, 0, 32'h0, 1); tick();
    drive(0, 0, 0, 32'h0, 1); tick();
    drive(0, 0, 0, 32'h0, 1);
    chk("t5_illegal_valid", 1, 64'(ovld[1]), 64'd1);
    chk("t5_illegal", 1, 64'(oill[1]), 64'd1);
    chk("t5_illegal_imm", 1, o_imm(1), 64'd0);
    chk("t5_illegal_type", 1, 64'(typ1), 64'd0);
    tick();

    // Reset with entries in flight.
    drive(0, 0, 1, 32'hFE000EE3, 0); tick();
    drive(0, 0, 1, 32'h123450B7, 0); tick();
    drive(1, 0, 1, 32'hFF9FF06F, 0); tick();
    drive(0, 0, 0, 32'h0, 1);
    chk("t6_valid", 0, 64'(ovld), 64'd0);
    chk("t6_imm", 1, o_imm(1), 64'd0);
    chk("t6_in_ready", 0, 64'(irdy), 64'h7);
    tick();

    // Randomized traffic with occasional flush and reset.
    for (int n = 0; n < 400; n++) begin
      rv = $urandom();
      drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 3) != 0), {rv[31:7], OPS[$urandom_range(0, 11)]},
            ($urandom_range(0, 3) != 0));
      tick();
    end

    // Drain and confirm every accepted entry came out.
    for (int n = 0; n < 10; n++) begin drive(0, 0, 0, 32'h0, 1); tick(); end
    for (int d = 0; d < 3; d++) chk("drain_empty", d, 64'(q_tl[d] - q_hd[d]), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
